// File: rtl/muldiv_unit_e.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Ports: clk, rst (sync, active-high), flushE, MulDivE, funct3E, SrcAE,
//   SrcBE in; StallMD, DoneMD, ResultMD out. Optional single-cycle
//   multiplier selected by defining MULDIV_FAST_MUL_EN.
module muldiv_unit_e #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flushE,
  input  logic                  MulDivE,
  input  logic [2:0]            funct3E,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  output logic                  StallMD,
  output logic                  DoneMD,
  output logic [DATA_WIDTH-1:0] ResultMD
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [W-1:0]         acc_q;
  logic [W-1:0]         lo_q;
  logic [W-1:0]         opb_q;
  logic [2:0]           f3_q;
  logic                 negq_q;
  logic                 negr_q;

  logic         is_div;
  logic         sgn_a_op;
  logic         sgn_b_op;
  logic         sa;
  logic         sb;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;
  logic         div_zero;
  logic         div_ovf;
  logic [W-1:0] spec_res;

  assign is_div   = funct3E[2];
  assign sgn_a_op = (funct3E == 3'b001) || (funct3E == 3'b010) ||
                    (funct3E == 3'b100) || (funct3E == 3'b110);
  assign sgn_b_op = (funct3E == 3'b001) || (funct3E == 3'b100) ||
                    (funct3E == 3'b110);
  assign sa       = sgn_a_op & SrcAE[W-1];
  assign sb       = sgn_b_op & SrcBE[W-1];
  assign mag_a    = sa ? -SrcAE : SrcAE;
  assign mag_b    = sb ? -SrcBE : SrcBE;
  assign div_zero = is_div && (SrcBE == '0);
  assign div_ovf  = is_div && !funct3E[0] &&
                    (SrcAE == {1'b1, {(W-1){1'b0}}}) &&
                    (SrcBE == {W{1'b1}});
  // Divide-by-zero: quotient all ones, remainder is the dividend.
  // Signed overflow: quotient is the dividend, remainder zero.
  assign spec_res = div_zero ? (funct3E[1] ? SrcAE : {W{1'b1}})
                             : (funct3E[1] ? '0 : SrcAE);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*W-1:0] fast_prod;
  logic [W-1:0]          fast_res;
  assign fast_prod = $signed({sgn_a_op & SrcAE[W-1], SrcAE}) *
                     $signed({sgn_b_op & SrcBE[W-1], SrcBE});
  assign fast_res  = (funct3E[1:0] == 2'b00) ? fast_prod[W-1:0]
                                             : fast_prod[2*W-1:W];
`endif

  // Shift-add step: {acc, lo} holds the product, lo shifts the multiplier out.
  logic [W:0] mul_sum;
  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);

  // Restoring divide step over a W+1-bit trial remainder.
  logic [W:0] div_sh;
  logic [W:0] div_diff;
  assign div_sh   = {acc_q, lo_q[W-1]};
  assign div_diff = div_sh - {1'b0, opb_q};

  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   fix_res;

  assign prod    = {acc_q, lo_q};
  assign prod_s  = negq_q ? -prod : prod;
  assign quo     = negq_q ? -lo_q : lo_q;
  assign rem     = negr_q ? -acc_q : acc_q;
  assign fix_res = f3_q[2] ? (f3_q[1] ? rem : quo)
                 : ((f3_q[1:0] == 2'b00) ? prod_s[W-1:0]
                                         : prod_s[2*W-1:W]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      f3_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      ResultMD <= '0;
    end else if (flushE) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (MulDivE) begin
            f3_q   <= funct3E;
            negq_q <= sa ^ sb;
            negr_q <= sa;
            cnt_q  <= '0;
            if (div_zero || div_ovf) begin
              ResultMD <= spec_res;
              state_q  <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              ResultMD <= fast_res;
              state_q  <= DONE;
            end
`endif
            else begin
              acc_q   <= '0;
              lo_q    <= mag_a;
              opb_q   <= mag_b;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (f3_q[2]) begin
            if (!div_diff[W]) begin
              acc_q <= div_diff[W-1:0];
              lo_q  <= {lo_q[W-2:0], 1'b1};
            end else begin
              acc_q <= div_sh[W-1:0];
              lo_q  <= {lo_q[W-2:0], 1'b0};
            end
          end else begin
            acc_q <= mul_sum[W:1];
            lo_q  <= {mul_sum[0], lo_q[W-1:1]};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_WIDTH'(W-1)) state_q <= FIX;
        end
        FIX: begin
          ResultMD <= fix_res;
          state_q  <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign StallMD = !flushE &&
                   (((state_q == IDLE) && MulDivE) ||
                    (state_q == CALC) || (state_q == FIX));
  assign DoneMD  = !flushE && (state_q == DONE);

endmodule

// File: tb/tb_muldiv_unit_e.sv
// Scoreboard testbench for muldiv_unit_e.
// Expected results are queued at issue and popped on DoneMD.
module tb_muldiv_unit_e;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flushE;
  logic        MulDivE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        StallMD;
  logic        DoneMD;
  logic [31:0] ResultMD;

  int nchk  = 0;
  int nfail = 0;
  int cyc   = 0;

  logic [31:0] q_res[$];
  int          q_cyc[$];
  string       q_tag[$];

  muldiv_unit_e dut (
    .clk      (clk),
    .rst      (rst),
    .flushE   (flushE),
    .MulDivE  (MulDivE),
    .funct3E  (funct3E),
    .SrcAE    (SrcAE),
    .SrcBE    (SrcBE),
    .StallMD  (StallMD),
    .DoneMD   (DoneMD),
    .ResultMD (ResultMD)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [31:0] r;
    int          c;
    string       t;
    if (!rst && DoneMD === 1'b1) begin
      if (q_res.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        r = q_res.pop_front();
        c = q_cyc.pop_front();
        t = q_tag.pop_front();
        chk({t, "_res"}, ResultMD, r);
        chk({t, "_cyc"}, cyc, c);
      end
    end
  end

  function automatic logic [31:0] ref_res(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa_l;
    longint sb_l;
    longint ua_l;
    longint ub_l;
    logic [63:0] p;
    logic ovf;
    sa_l = longint'(signed'(a));
    sb_l = longint'(signed'(b));
    ua_l = longint'({32'h0, a});
    ub_l = longint'({32'h0, b});
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p    = '0;
    ref_res = '0;
    case (f)
      3'd0: begin p = ua_l * ub_l; ref_res = p[31:0]; end
      3'd1: begin p = sa_l * sb_l; ref_res = p[63:32]; end
      3'd2: begin p = sa_l * ub_l; ref_res = p[63:32]; end
      3'd3: begin p = ua_l * ub_l; ref_res = p[63:32]; end
      3'd4: ref_res = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000
                    : 32'(signed'(a) / signed'(b));
      3'd5: ref_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: ref_res = (b == 0) ? a : ovf ? 32'h0
                    : 32'(signed'(a) % signed'(b));
      default: ref_res = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (f[2] && (b == 0 ||
        (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    if (!f[2]) return MUL_LAT;
    return 34;
  endfunction

  // Called and returns at posedge+1; issues one op and tracks it to DONE.
  task automatic run_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat,
                        input bit hold);
    int n;
    bit seen;
    MulDivE = 1'b1;
    funct3E = f;
    SrcAE   = a;
    SrcBE   = b;
    q_res.push_back(exp);
    q_cyc.push_back(cyc + lat);
    q_tag.push_back(tag);
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (DoneMD) begin
        seen = 1'b1;
        chk({tag, "_stall_at_done"}, StallMD, 0);
      end else if (StallMD) begin
        n++;
      end
      @(posedge clk);
      #1;
      MulDivE = hold && !seen;
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_stall_cnt"}, n, lat);
  endtask

  task automatic run_ref(input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    run_op(tag, f, a, b, ref_res(f, a, b), ref_lat(f, a, b), 1'b0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : main
    int t0;
    int nd;
    logic [31:0] prev;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rf;
    rst     = 1'b1;
    flushE  = 1'b0;
    MulDivE = 1'b0;
    funct3E = '0;
    SrcAE   = '0;
    SrcBE   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", StallMD, 0);
    chk("rst_done", DoneMD, 0);
    chk("rst_result", ResultMD, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("mul_7x6", 3'd0, 32'd7, 32'd6, 32'h2A, MUL_LAT, 1'b0);
    run_op("mulh_m2x3", 3'd1, 32'hFFFF_FFFE, 32'd3,
           32'hFFFF_FFFF, MUL_LAT, 1'b0);
    run_op("mulhu_m2x3", 3'd3, 32'hFFFF_FFFE, 32'd3,
           32'h2, MUL_LAT, 1'b0);
    run_op("mulhsu_m2x3", 3'd2, 32'hFFFF_FFFE, 32'd3,
           32'hFFFF_FFFF, MUL_LAT, 1'b0);
    run_op("mulhsu_3xm2", 3'd2, 32'd3, 32'hFFFF_FFFE,
           32'h2, MUL_LAT, 1'b0);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, 34, 1'b0);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 34, 1'b0);
    run_op("div_7_m2", 3'd4, 32'd7, 32'hFFFF_FFFE,
           32'hFFFF_FFFD, 34, 1'b0);
    run_op("rem_7_m2", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'h1, 34, 1'b0);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'h2, 34, 1'b0);
    run_op("divu_5_0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("rem_5_0", 3'd6, 32'd5, 32'd0, 32'h5, 1, 1'b0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1, 1'b0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 1, 1'b0);

    // Flush an in-flight DIVU, then reissue it.
    t0      = cyc;
    MulDivE = 1'b1;
    funct3E = 3'd5;
    SrcAE   = 32'd100;
    SrcBE   = 32'd7;
    @(posedge clk);
    #1;
    MulDivE = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("flush_at_t10", cyc, t0 + 10);
    flushE = 1'b1;
    prev   = ResultMD;
    @(negedge clk);
    chk("flush_stall", StallMD, 0);
    chk("flush_done", DoneMD, 0);
    @(posedge clk);
    #1;
    flushE = 1'b0;
    @(negedge clk);
    chk("flush_idle_stall", StallMD, 0);
    chk("flush_result_hold", ResultMD, prev);
    @(posedge clk);
    #1;
    run_op("divu_after_flush", 3'd5, 32'd100, 32'd7, 32'hE, 34, 1'b0);

    // MulDivE held through DONE must not retrigger.
    run_op("mul_hold", 3'd0, 32'd9, 32'd9, 32'd81, MUL_LAT, 1'b1);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (DoneMD) nd++;
    end
    chk("hold_extra_done", nd, 0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 10; k++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (k % 4 == 3) ? 32'h0 : $urandom;
      if (k % 3 == 1) rb = rb >> $urandom_range(8, 28);
      run_ref($sformatf("rand%0d_f%0d", k, rf), rf, ra, rb);
    end

    // Reset in the middle of a multiply.
    t0      = cyc;
    MulDivE = 1'b1;
    funct3E = 3'd0;
    SrcAE   = 32'd7;
    SrcBE   = 32'd6;
    if (MUL_LAT == 1) begin
      q_res.push_back(32'h2A);
      q_cyc.push_back(t0 + 1);
      q_tag.push_back("mul_pre_rst");
    end
    @(posedge clk);
    #1;
    MulDivE = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_at_t6", cyc, t0 + 6);
    @(negedge clk);
    chk("rst_mid_stall", StallMD, 0);
    chk("rst_mid_done", DoneMD, 0);
    chk("rst_mid_result", ResultMD, 0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (DoneMD) nd++;
    end
    chk("rst_mid_no_done", nd, 0);
    @(posedge clk);
    #1;
    run_op("mul_after_rst", 3'd0, 32'd7, 32'd6, 32'h2A, MUL_LAT, 1'b0);

    repeat (5) @(posedge clk);
    chk("sb_empty", q_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit_e.md
Name: muldiv_unit_e

Overview:
Iterative RV32M multiply/divide unit in the Execute stage, next to the ALU. It consumes the decoded control fields (funct3E plus a MulDivE strobe) that the decode-to-execute control register delivers, together with the forwarded operands. It holds the pipeline with a stall while it iterates. It then presents a 32-bit result for one cycle so the execute-to-memory register can capture it.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH
CNT_WIDTH, 5, iteration counter width, equal to log2(DATA_WIDTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
flushE  input  1  synchronous abort of the in-flight op (branch mispredict/jump)
MulDivE  input  1  Execute instruction is an M-extension op
funct3E  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcAE  input  DATA_WIDTH  rs1 operand, post-forwarding
SrcBE  input  DATA_WIDTH  rs2 operand, post-forwarding
StallMD  output  1  to hazard unit: freeze F/D/E and bubble M
DoneMD  output  1  one-cycle pulse; ResultMD valid
ResultMD  output  DATA_WIDTH  result

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. There are no asynchronous paths.
- Reset values: state IDLE, counter 0, StallMD 0, DoneMD 0, ResultMD 0, all internal accumulators 0.
- States:
  - IDLE: waiting for an op.
  - CALC: DATA_WIDTH iterations.
  - FIX: sign correction and selection of the high/low word.
  - DONE: result presented.
- IDLE with MulDivE=1 (cycle T):
  - Latch operands and funct3.
  - Record sign flags. Signed ops take the absolute values of their signed operands. MULHSU treats only SrcAE as signed.
  - Go to CALC with counter 0.
- CALC, MUL family: shift-add on a 2*DATA_WIDTH product, one multiplier bit per cycle.
- CALC, DIV family: restoring division, one quotient bit per cycle, over a DATA_WIDTH+1-bit partial remainder.
- CALC exits to FIX when the counter reaches DATA_WIDTH-1, so CALC occupies cycles T+1..T+32.
- FIX (T+33):
  - Negate the product if the operand signs differ.
  - Quotient sign is signA XOR signB. Remainder takes the sign of the dividend.
  - Select the low word for MUL, the high word for MULH/MULHSU/MULHU, the quotient for DIV/DIVU, the remainder for REM/REMU.
  - Register the selection into ResultMD.
- DONE (T+34): DoneMD=1 and StallMD=0, so the pipeline advances. MulDivE is ignored in DONE (no re-trigger). Next state is IDLE.
- StallMD = (IDLE & MulDivE & ~flushE) | CALC | FIX. The stall is combinational in the start cycle. The total stall is 34 cycles.
- Special cases, detected in IDLE; these go straight to DONE (done at T+1, stall for 1 cycle):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = SrcAE.
  - Signed overflow (DIV/REM, SrcAE = 0x80000000, SrcBE = 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- ResultMD holds its value until the next DONE. DoneMD is low in every state except DONE.
- flushE, in any state: next state IDLE, no DoneMD, StallMD forced 0 in the flush cycle, ResultMD unchanged.
- rst takes priority over flushE. A rst mid-operation returns every output to its reset value on the next edge.
- All arithmetic is modulo 2^DATA_WIDTH. Negating 0x80000000 yields 0x80000000, which is correct for the unsigned magnitude path.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MUL-family ops compute the full 64-bit product with a single-cycle multiplier in IDLE, skip CALC/FIX, and go to DONE. Stall is 1 cycle and DoneMD is at T+1. The divide path is unchanged.
- Undefined: MUL-family ops use the iterative shift-add path with a 34-cycle stall. No hardware multiplier is inferred.

Test Plan:
- MUL, SrcAE=7, SrcBE=6 -> StallMD high T..T+33; DoneMD at T+34; ResultMD=0x0000002A (fast build: DoneMD at T+1).
- MULH, SrcAE=0xFFFFFFFE (-2), SrcBE=3 -> ResultMD=0xFFFFFFFF. Same inputs with MULHU -> ResultMD=0x00000002.
- DIV/REM, SrcAE=0xFFFFFFF9 (-7), SrcBE=2 -> DIV ResultMD=0xFFFFFFFD, REM ResultMD=0xFFFFFFFF, each done at T+34.
- DIVU 5/0 -> ResultMD=0xFFFFFFFF with DoneMD at T+1. REM 5/0 -> 0x00000005. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- DIVU 100/7 with flushE pulsed at T+10 -> StallMD low at T+10, state IDLE at T+11, no DoneMD. A new DIVU 100/7 at T+12 -> ResultMD=0x0000000E at T+46.
- rst asserted at T+5 of a MUL -> from T+6 all outputs 0 and state IDLE. MulDivE held high through DONE -> exactly one DoneMD pulse.
